// File: rtl/top_fifo_burst_wr.sv
// top_fifo_burst_wr: gathers a burst from one selected producer into a FIFO and hands it to the host over the parallel SPI pads
module top_fifo_burst_wr #(
  parameter int SPI_WIDTH = 32,
  parameter int ADDR_WIDTH_FIFO = 3,
  parameter int NUM_CH = 4,
  parameter int LEN_W = 8,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk_chip,
  input  logic                        reset_chip,
  input  logic                        O_spi_sck,
  input  logic                        O_spi_cs_n,
  output logic [SPI_WIDTH-1:0]        IO_spi_data,
  output logic                        config_req,
  output logic                        config_ready,
  input  logic                        config_paulse,
  input  logic [3:0]                  config_data,
  input  logic [CH_W-1:0]             config_ch,
  input  logic [LEN_W-1:0]            config_len,
  output logic [NUM_CH-1:0]           wr_ready,
  input  logic [NUM_CH-1:0]           wr_req,
  input  logic [NUM_CH*SPI_WIDTH-1:0] wr_data,
  output logic                        burst_done,
  output logic                        underrun
);
  localparam int DEPTH = 1 << ADDR_WIDTH_FIFO;
  localparam int HW = 8 + LEN_W;
  localparam logic [ADDR_WIDTH_FIFO:0] FULL = (ADDR_WIDTH_FIFO+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, CONFIG, WAIT, XFER, DONE} state_t;
  state_t state, state_nxt;
  logic [CH_W-1:0] ch_q;
  logic [LEN_W-1:0] len_q, wr_cnt;
  logic [3:0] cfg_data_q;
  logic [SPI_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH_FIFO-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH_FIFO:0] count;
  logic sck_s1, sck_sync, sck_d, cs_s1, cs_sync, cs_d_sync;
  logic start, can_wr, push, pop_ev, pop, sck_rise;
  logic [HW-1:0] hdr_top;
  logic [SPI_WIDTH-1:0] hdr;
  assign start = state == IDLE && config_paulse && config_len != '0;
  assign can_wr = state inside {CONFIG, WAIT, XFER} && count != FULL && wr_cnt < len_q;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_rdy
    assign wr_ready[c] = can_wr && ch_q == CH_W'(c);
  end
  assign push = |(wr_req & wr_ready);
  assign sck_rise = sck_sync & ~sck_d;
  assign pop_ev = state == XFER && sck_rise && !cs_sync;
  assign pop = pop_ev && count != '0;
  assign config_ready = state == IDLE;
  assign config_req = state inside {CONFIG, WAIT};
  assign burst_done = state == DONE;
  // header: tag, channel, length packed from the MSB down, zero padded or truncated to the word
  assign hdr_top = {cfg_data_q, 4'(ch_q), len_q};
  if (SPI_WIDTH >= HW) begin : g_hdr_pad
    assign hdr = SPI_WIDTH'(hdr_top) << (SPI_WIDTH - HW);
  end else begin : g_hdr_cut
    assign hdr = hdr_top[HW-1 -: SPI_WIDTH];
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? CONFIG : IDLE;
      CONFIG:  state_nxt = WAIT;
      WAIT:    state_nxt = cs_sync ? WAIT : XFER;
      XFER:    state_nxt = (cs_sync && cs_d_sync) ? DONE : XFER;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_chip)
    if (push) mem[wr_ptr] <= wr_data[ch_q*SPI_WIDTH +: SPI_WIDTH];
  always_ff @(posedge clk_chip or posedge reset_chip)
    if (reset_chip) begin
      state <= IDLE;
      {sck_s1, sck_sync, sck_d, cs_s1, cs_sync, cs_d_sync} <= '1;
      ch_q <= '0;
      len_q <= '0;
      cfg_data_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      wr_cnt <= '0;
      underrun <= 1'b0;
      IO_spi_data <= '0;
    end else begin
      state <= state_nxt;
      {sck_s1, sck_sync, sck_d} <= {O_spi_sck, sck_s1, sck_sync};
      {cs_s1, cs_sync, cs_d_sync} <= {O_spi_cs_n, cs_s1, cs_sync};
      if (start) begin
        ch_q <= config_ch;
        len_q <= config_len;
        cfg_data_q <= config_data;
      end
      if (state == DONE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        wr_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (push) wr_cnt <= wr_cnt + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{ADDR_WIDTH_FIFO{1'b0}}, push} - {{ADDR_WIDTH_FIFO{1'b0}}, pop};
      end
      underrun <= start ? 1'b0 : (pop_ev && !pop) ? 1'b1 : underrun;
      IO_spi_data <= pop_ev ? (pop ? mem[rd_ptr] : '0) : cs_sync ? hdr : IO_spi_data;
    end
endmodule

// File: tb/tb_top_fifo_burst_wr.sv
// tb_top_fifo_burst_wr: directed bursts with a scoreboard of expected host words
module tb_top_fifo_burst_wr;
  logic clk_chip = 1'b0, reset_chip = 1'b1;
  logic O_spi_sck = 1'b0, O_spi_cs_n = 1'b1;
  logic [31:0] IO_spi_data;
  logic config_req, config_ready, config_paulse = 1'b0;
  logic [3:0] config_data = '0;
  logic [1:0] config_ch = '0;
  logic [7:0] config_len = '0;
  logic [3:0] wr_ready, wr_req = '0;
  logic [127:0] wr_data = '0;
  logic burst_done, underrun;
  int checks = 0, errors = 0;
  int max_cnt, rises;
  logic [3:0] others_seen;
  logic [31:0] exp_q[$];
  logic [31:0] d;

  top_fifo_burst_wr #(.SPI_WIDTH(32), .ADDR_WIDTH_FIFO(3), .NUM_CH(4), .LEN_W(8)) dut (
    .clk_chip(clk_chip), .reset_chip(reset_chip), .O_spi_sck(O_spi_sck), .O_spi_cs_n(O_spi_cs_n),
    .IO_spi_data(IO_spi_data), .config_req(config_req), .config_ready(config_ready),
    .config_paulse(config_paulse), .config_data(config_data), .config_ch(config_ch),
    .config_len(config_len), .wr_ready(wr_ready), .wr_req(wr_req), .wr_data(wr_data),
    .burst_done(burst_done), .underrun(underrun));

  always #5 clk_chip = ~clk_chip;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic [3:0] tag, input logic [1:0] ch, input logic [7:0] len);
    @(negedge clk_chip);
    config_paulse = 1'b1; config_data = tag; config_ch = ch; config_len = len;
    @(negedge clk_chip);
    config_paulse = 1'b0;
  endtask

  task automatic produce(input int ch, input logic [31:0] base, input int n);
    int i = 0, t = 0;
    logic prev = 1'b0;
    while (i < n && t < 3000) begin
      @(negedge clk_chip);
      t++;
      wr_req = '0; wr_req[ch] = 1'b1;
      wr_data[ch*32 +: 32] = base + i;
      others_seen |= wr_ready & ~(4'b1 << ch);
      if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
      if (wr_ready[ch] && !prev) rises++;
      prev = wr_ready[ch];
      if (wr_ready[ch]) i++;
    end
    @(negedge clk_chip);
    wr_req = '0;
    chk("produce_count", i, n);
  endtask

  task automatic host_pop(output logic [31:0] v);
    @(negedge clk_chip);
    O_spi_sck = 1'b1;
    repeat (4) @(negedge clk_chip);
    v = IO_spi_data;
    O_spi_sck = 1'b0;
    repeat (3) @(negedge clk_chip);
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] v, e;
    host_pop(v);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk(tag, v, e);
  endtask

  task automatic end_burst();
    logic seen = 1'b0;
    O_spi_cs_n = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_chip);
      seen = burst_done;
    end
    chk("burst_done_seen", seen, 1);
    @(negedge clk_chip);
    chk("burst_done_pulse", burst_done, 0);
    chk("done_count", dut.count, 0);
    chk("done_idle", config_ready, 1);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk_chip);
    chk("rst_ready", config_ready, 1);
    chk("rst_req", config_req, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_data", IO_spi_data, 0);
    reset_chip = 1'b0;
    // basic burst on channel 2; a second pulse while busy must be ignored
    configure(4'h3, 2'd2, 8'd5);
    configure(4'h0, 2'd0, 8'd1);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'hA0 + i);
    others_seen = '0; max_cnt = 0; rises = 0;
    produce(2, 32'hA0, 5);
    chk("wr_ready2_drop", wr_ready[2], 0);
    chk("others_never_ready", others_seen, 0);
    O_spi_cs_n = 1'b0;
    repeat (4) @(negedge clk_chip);
    chk("xfer_req_clear", config_req, 0);
    for (int i = 0; i < 5; i++) pop_chk("burst1_pop");
    end_burst();
    // long burst across pointer wrap with a slow host
    configure(4'h1, 2'd3, 8'd20);
    for (int i = 0; i < 20; i++) exp_q.push_back(32'h100 + i);
    max_cnt = 0; rises = 0;
    O_spi_cs_n = 1'b0;
    fork
      produce(3, 32'h100, 20);
      begin
        repeat (12) @(negedge clk_chip);
        for (int i = 0; i < 20; i++) pop_chk("wrap_pop");
      end
    join
    chk("max_count", max_cnt, 8);
    chk("ready_toggles", rises >= 2, 1);
    end_burst();
    // header while cs_n high, then discard of unread words
    configure(4'hB, 2'd1, 8'd8);
    repeat (2) @(negedge clk_chip);
    chk("header", IO_spi_data, 32'hB108_0000);
    chk("cfg_req_set", config_req, 1);
    chk("cfg_ready_low", config_ready, 0);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'hC0 + i);
    produce(1, 32'hC0, 6);
    O_spi_cs_n = 1'b0;
    repeat (4) @(negedge clk_chip);
    pop_chk("discard_pop");
    pop_chk("discard_pop");
    end_burst();
    // underrun: three pops of two words
    configure(4'h0, 2'd0, 8'd3);
    exp_q.push_back(32'hD0); exp_q.push_back(32'hD1); exp_q.push_back(32'h0);
    produce(0, 32'hD0, 2);
    O_spi_cs_n = 1'b0;
    repeat (4) @(negedge clk_chip);
    for (int i = 0; i < 3; i++) pop_chk("underrun_pop");
    chk("underrun_set", underrun, 1);
    end_burst();
    chk("underrun_sticky", underrun, 1);
    // underrun clears on CONFIG entry; then async reset in XFER
    @(negedge clk_chip);
    config_paulse = 1'b1; config_data = 4'h2; config_ch = 2'd0; config_len = 8'd5;
    chk("underrun_before_cfg", underrun, 1);
    @(negedge clk_chip);
    config_paulse = 1'b0;
    chk("underrun_cleared", underrun, 0);
    produce(0, 32'hE0, 3);
    O_spi_cs_n = 1'b0;
    repeat (4) @(negedge clk_chip);
    chk("pre_rst_count", dut.count, 3);
    chk("pre_rst_xfer", config_req, 0);
    @(negedge clk_chip);
    #2 reset_chip = 1'b1;
    #1;
    chk("arst_ready", config_ready, 1);
    chk("arst_req", config_req, 0);
    chk("arst_data", IO_spi_data, 0);
    chk("arst_count", dut.count, 0);
    chk("arst_wr_ready", wr_ready, 0);
    O_spi_cs_n = 1'b1;
    @(negedge clk_chip);
    reset_chip = 1'b0;
    configure(4'h5, 2'd1, 8'd0);
    repeat (2) @(negedge clk_chip);
    chk("len0_ready", config_ready, 1);
    chk("len0_req", config_req, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/top_fifo_burst_wr.md
# top_fifo_burst_wr

Parametrised, single-clock successor to the chip-to-FPGA write-back bridge. Gathers a programmable-length burst of SPI_WIDTH-bit words from one of NUM_CH ASIC-side producers into an internal synchronous FIFO. Hands the words out over the parallel SPI pad interface, with O_spi_sck/O_spi_cs_n oversampled in the clk_chip domain. Adds runtime burst length, channel select, underrun detection and a burst_done pulse.

## Interface
- SPI_WIDTH, 32: data word width; must be ≥ 8.
- ADDR_WIDTH_FIFO, 3: FIFO depth = 2^ADDR_WIDTH_FIFO words.
- NUM_CH, 4: producer channels, 1..16; CH_W = max(1, clog2(NUM_CH)).
- LEN_W, 8: width of burst length field.

Ports:
- clk_chip  in  1  sole clock.
- reset_chip  in  1  asynchronous, active-high reset.
- O_spi_sck  in  1  host word strobe, asynchronous, synchronised internally.
- O_spi_cs_n  in  1  host select, active low, asynchronous.
- IO_spi_data  out  SPI_WIDTH  registered word to host.
- config_req  out  1  request to host to start a read.
- config_ready  out  1  high in IDLE.
- config_paulse  in  1  one-cycle start pulse.
- config_data  in  4  header tag.
- config_ch  in  CH_W  producer selected for this burst.
- config_len  in  LEN_W  burst length in words.
- wr_ready  out  NUM_CH  per-channel ready.
- wr_req  in  NUM_CH  per-channel write strobe.
- wr_data  in  NUM_CH*SPI_WIDTH  channel c occupies bits [c*SPI_WIDTH +: SPI_WIDTH].
- burst_done  out  1  one-cycle pulse at end of burst.
- underrun  out  1  sticky: host popped an empty FIFO.

## Operation
- States: IDLE, CONFIG, WAIT, XFER, DONE.
- IDLE → CONFIG on config_paulse with config_len ≠ 0. The pulse latches config_ch, config_len and config_data. A pulse with config_len = 0 is ignored and the state stays IDLE.
- CONFIG → WAIT after one cycle; config_req is set in CONFIG.
- WAIT → XFER when cs_sync = 0; config_req clears on XFER entry.
- XFER → DONE when cs_sync = 1 and cs_d_sync = 1, i.e. cs has been high for two synchronised samples.
- DONE → IDLE after one cycle:
  - FIFO pointers and count cleared.
  - burst_done = 1 for that cycle.
  - Unread words are discarded.
- Write side:
  - wr_ready[c] = (c == ch_q) && state ∈ {CONFIG, WAIT, XFER} && count < DEPTH && wr_cnt < len_q.
  - Push on wr_req[ch_q] && wr_ready[ch_q]; wr_cnt increments.
  - wr_req on an unselected or not-ready channel is dropped.
- Read side:
  - O_spi_sck and O_spi_cs_n each pass a 2-flop synchroniser; a third flop on sck gives rising-edge detect.
  - In XFER, on sck_rise with cs_sync = 0: pop the head word into IO_spi_data.
  - If the FIFO is empty at that point, IO_spi_data ← 0 and underrun ← 1.
- Header: while cs_sync = 1, IO_spi_data = {cfg_data_q, 4-bit ch_q zero-extended, len_q zero-extended/truncated into the next LEN_W bits, zeros}.
- Counters:
  - count and pointers are ADDR_WIDTH_FIFO+1 / ADDR_WIDTH_FIFO bits; pointers wrap modulo DEPTH.
  - wr_cnt is LEN_W bits and saturates at len_q.

## Timing
- Reset values:
  - state = IDLE; config_ready = 1.
  - config_req = 0, wr_ready = 0, burst_done = 0, underrun = 0, IO_spi_data = 0.
  - Pointers, count and wr_cnt = 0; synchroniser flops = 1.
- Reset asserted mid-burst returns all of the above immediately, asynchronously.
- Push latency: a word written in cycle t is poppable from t+1.
- Pop latency: IO_spi_data updates 3 clk_chip cycles after the O_spi_sck rising edge, i.e. 2 synchroniser flops plus the output register.
- Host must hold sck high ≥ 2 and low ≥ 2 clk_chip cycles.
- Host must sample IO_spi_data ≥ 4 cycles after its rising edge.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push when count = DEPTH is blocked by wr_ready, since wr_ready uses the current count.
- A pop in the same cycle does not unblock the push until the next cycle.
- underrun clears only on entry to CONFIG.
- config_paulse outside IDLE is ignored.

## Test plan
- config_ch = 2, config_len = 5, channel 2 streams 0xA0..0xA4, then host pops 5 words → IO_spi_data = 0xA0..0xA4 in order; wr_ready[2] drops after the 5th push; wr_ready[0,1,3] stay 0 throughout.
- DEPTH = 8, config_len = 20, producer always requests, host pops slowly → count never exceeds 8; wr_ready toggles with pops; all 20 words arrive in order across pointer wrap.
- Host pops 3 words with only 2 pushed → third pop gives 0; underrun = 1 and remains 1 until the next CONFIG.
- cs_n raised with 4 words unread → DONE for one cycle, burst_done pulse, count = 0; the next burst returns only its own data.
- While cs_n is high after config with config_data = 0xB, ch = 1, len = 8 → IO_spi_data = {4'hB, 4'h1, 8'h08, 16'h0} for SPI_WIDTH = 32.
- reset_chip asserted in XFER with count = 3 → state IDLE, config_req = 0, IO_spi_data = 0, count = 0 without waiting for a clock edge; a config_paulse with config_len = 0 afterwards leaves config_ready = 1.
